// File: rtl/ram_pkg.sv
// Shared constants and types for the program/data RAM arbiter.
package ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    // Records which requester currently holds a lock.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_e;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way picker: a lone requester wins outright; on contention either requester 0
// wins (fixed priority) or the one that did not win last time does.
module ram_arb_pick (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    input  logic       fixed_prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (fixed_prio_i || rr_last_i) ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port program/data RAM with
// locked bursts and a one-cycle read-return pipeline.
module ram_arbiter #(
    parameter int ADDR_W     = ram_pkg::ADDR_W,
    parameter int DATA_W     = ram_pkg::DATA_W,
    parameter int MAX_BURST  = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    import ram_pkg::*;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
    localparam logic       FIXED     = (FIXED_PRIO != 0);

    own_state_e        state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              hand_q, hand_d;
    logic [3:0]        burst_q, burst_d;
    logic              rd_q, rd_d;
    logic              tag_q, tag_d;
    logic [DATA_W-1:0] hold0_q, hold1_q;

    logic [1:0] req_v, we_v, lock_v, pick_gnt, gnt, gnt_act;
    logic       own_id;

    assign req_v  = {m1_req, m0_req};
    assign we_v   = {m1_we, m0_we};
    assign lock_v = {m1_lock, m0_lock};
    assign own_id = (state_q == OWN1);

    // After a lock ends, fixed priority is suspended for one cycle so the
    // other requester is handed the RAM; rr_last already names the old owner.
    ram_arb_pick u_pick (
        .req_i        (req_v),
        .rr_last_i    (rr_last_q),
        .fixed_prio_i (FIXED && !hand_q),
        .gnt_o        (pick_gnt)
    );

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        burst_d   = burst_q;
        hand_d    = 1'b0;
        gnt       = '0;
        case (state_q)
            IDLE: begin
                gnt = pick_gnt;
                if (|pick_gnt) begin
                    rr_last_d = pick_gnt[REQ_LOAD];
                    if (lock_v[pick_gnt[REQ_LOAD]]) begin
                        if (BURST_MAX > 4'd1) begin
                            state_d = pick_gnt[REQ_LOAD] ? OWN1 : OWN0;
                            burst_d = 4'd1;
                        end else begin
                            hand_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (req_v[own_id]) begin
                    gnt[own_id] = 1'b1;
                    rr_last_d   = own_id;
                    if (lock_v[own_id] && (burst_q + 4'd1 < BURST_MAX)) begin
                        burst_d = burst_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                        burst_d = '0;
                        hand_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    burst_d = '0;
                    hand_d  = 1'b1;
                end
            end
        endcase
    end

    assign gnt_act  = gnt & {2{reset_n}};
    assign m0_gnt   = gnt_act[REQ_CPU];
    assign m1_gnt   = gnt_act[REQ_LOAD];

    assign ram_addr = gnt_act[REQ_LOAD] ? m1_addr  : m0_addr;
    assign ram_din  = gnt_act[REQ_LOAD] ? m1_wdata : m0_wdata;
    assign ram_we   = |(gnt_act & we_v);

    assign rd_d     = |(gnt_act & ~we_v);
    assign tag_d    = gnt_act[REQ_LOAD];

    assign m0_rvalid = rd_q & ~tag_q;
    assign m1_rvalid = rd_q & tag_q;
    assign m0_rdata  = m0_rvalid ? ram_dout : hold0_q;
    assign m1_rdata  = m1_rvalid ? ram_dout : hold1_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            hand_q    <= 1'b0;
            burst_q   <= '0;
            rd_q      <= 1'b0;
            tag_q     <= 1'b0;
            hold0_q   <= '0;
            hold1_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            hand_q    <= hand_d;
            burst_q   <= burst_d;
            rd_q      <= rd_d;
            tag_q     <= tag_d;
            if (m0_rvalid) hold0_q <= ram_dout;
            if (m1_rvalid) hold1_q <= ram_dout;
        end
    end

endmodule
